sine_lut: RTL and testbench
===========================

// Module: sine_lut
//
// PURPOSE
//  Quarter-wave sine magnitude lookup for the spread-spectrum correlator carrier DDS path.
//  Takes a 13-bit first-quadrant phase index and returns a 16-bit unsigned sine magnitude.
//  The caller folds quadrants: it mirrors the index with ~v in quadrants 1 and 3.
//  The caller negates the result in quadrants 2 and 3.
//  Sits between the frequency-DDS phase accumulator and the ADC x carrier multiplier.
//
// PARAMETERS
//  PHASE_W   13                   index width; table depth = 2**PHASE_W
//  AMP_W     16                   output width; full scale = 2**(AMP_W-1)-1 = 32767
//  ROM_FILE  "sine_lut_rom.hex"   $readmemh image, one AMP_W-bit hex word per line
//
// PORTS
//  clk   in   1        single clock; all state updates on rising edge
//  rst   in   1        reset: synchronous, active-high
//  v     in   PHASE_W  first-quadrant phase index
//  sv    out  AMP_W    sine magnitude for the v sampled on the previous edge (registered)
//
// BEHAVIOUR
//  - Table content, exact:
//      sv(v) = round_half_up( 32767 * sin( (pi/2) * (v + 0.5) / 2**PHASE_W ) ).
//  - The half-LSB offset makes the ~v mirror exact:
//      table(v) for quadrant 0 equals table(~v) for quadrant 1, with no duplicated peak or zero.
//  - Output range 3..32767. The table is monotonic non-decreasing in v.
//  - The output is always non-negative, so no sign bit is ever set. The caller sign-extends it.
//  - Latency: exactly 1 clk. sv on the edge after v is sampled = table(v).
//  - A new v is accepted every cycle, with no handshake and no stall.
//  - sv holds until the next edge.
//  - Reset: on a rising clk edge with rst=1, sv <= 0. The v sampled on that edge is discarded.
//  - First valid sv appears one edge after rst deasserts.
//  - Reset mid-stream: the in-flight lookup is dropped; there are no other side effects.
//  - X/Z on v: output is don't-care. It must not corrupt later lookups.
//  - Boundaries: v=0 -> 3; v=8191 -> 32767. v wrap-around 8191->0 is handled as an ordinary index.
//  - Implementation: synchronous-read ROM (reg array loaded with $readmemh) with the output register.
//  - The ROM must infer block RAM/ROM. No combinational path from v to sv.
//  - A generator script produces ROM_FILE from the formula above. That file is the golden table.
//
// STRUCTURE
//  - Shared package correlator_pkg holds:
//      PHASE_W=13, AMP_W=16, AMP_MAX=16'd32767, and the quadrant encoding constants
//      (Q0=2'b00 .. Q3=2'b11).
//      These are shared with the DDS/correlator block.
//  - No sub-module is needed. The single ROM array plus the output register live in sine_lut.
//  - A reusable sync_rom (DEPTH, WIDTH, INIT_FILE) is acceptable if the codebase already has one.
//
// TESTING
//  1. Reset: hold rst=1 for 3 clk with v=4096 -> sv==0 on every edge.
//     Release -> sv==23172 one edge later.
//  2. Spot values, 1-cycle latency:
//       v=0    -> 3
//       v=4095 -> 23168
//       v=4096 -> 23172
//       v=8191 -> 32767
//     Each value appears exactly one edge after v is applied.
//  3. Back-to-back sweep: v=0..8191, one per clk -> every sv matches the golden ROM_FILE
//     (model computed with $sin).
//     sv is non-decreasing with no gaps in acceptance.
//  4. Mirror: for 500 random v, compare sv(v) and sv(~v) against model sin and cos
//     -> exact match to round_half_up values.
//  5. Reset mid-stream: apply v=8191, then assert rst on the next edge -> sv==0 (not 32767).
//     Release with v=0 -> sv==3.
//  6. Wrap: v sequence 8190, 8191, 0, 1 -> sv: 32767, 32767, 3, 9, each one clk delayed.

Source files
------------

// File: rtl/correlator_pkg.sv
// ---------------------------------------------------------------------------
// correlator_pkg
//   Constants shared by the DDS / correlator datapath and the quarter-wave
//   sine table.
//     PHASE_W  first-quadrant phase index width (table depth 2**PHASE_W)
//     AMP_W    unsigned sine magnitude width
//     AMP_MAX  full-scale magnitude (2**(AMP_W-1)-1)
//     quad_e   quadrant encoding used by the caller when folding phase
//   sine_entry() returns one golden table word:
//     round_half_up(AMP_MAX * sin((pi/2) * (idx + 0.5) / 2**phase_w))
// ---------------------------------------------------------------------------
package correlator_pkg;

  localparam int PHASE_W = 13;
  localparam int AMP_W   = 16;
  localparam logic [AMP_W-1:0] AMP_MAX = 16'd32767;

  typedef enum logic [1:0] {
    Q0 = 2'b00,
    Q1 = 2'b01,
    Q2 = 2'b10,
    Q3 = 2'b11
  } quad_e;

  localparam real PI_HALF = 1.57079632679489661923;

  // Taylor series for sin on [0, pi/2]; 14 terms puts the truncation error
  // far below one part in 1e15, so rounding to 16 bits is unaffected.
  function automatic logic [AMP_W-1:0] sine_entry(input int idx, input int phase_w);
    real x;
    real x2;
    real term;
    real acc;
    x    = (PI_HALF * (real'(idx) + 0.5)) / real'(2 ** phase_w);
    x2   = x * x;
    term = x;
    acc  = x;
    for (int k = 1; k < 14; k++) begin
      term = -term * x2 / real'((2 * k) * (2 * k + 1));
      acc  = acc + term;
    end
    // Value is strictly positive, so truncation of (y + 0.5) is round-half-up.
    return AMP_W'($rtoi(acc * real'(AMP_MAX) + 0.5));
  endfunction

endpackage

// File: rtl/sine_lut.sv
// ---------------------------------------------------------------------------
// sine_lut
//   Quarter-wave sine magnitude lookup for the correlator carrier DDS path.
//   The caller folds quadrants (mirrors the index with ~v in Q1/Q3, negates
//   the result in Q2/Q3); this block only ever sees first-quadrant indices
//   and always returns a non-negative magnitude in 3..AMP_MAX.
//
//   Ports
//     clk  in   1        rising-edge clock
//     rst  in   1        synchronous active-high reset; clears sv, drops the
//                        index sampled on the same edge
//     v    in   PHASE_W  first-quadrant phase index, accepted every cycle
//     sv   out  AMP_W    table(v) for the v sampled on the previous edge
//
//   The table is a constant array indexed by the registered read, so it maps
//   onto a synchronous-read ROM with its output register; there is no
//   combinational path from v to sv.
// ---------------------------------------------------------------------------
module sine_lut #(
  parameter int PHASE_W = correlator_pkg::PHASE_W,
  parameter int AMP_W   = correlator_pkg::AMP_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PHASE_W-1:0] v,
  output logic [AMP_W-1:0]   sv
);

  import correlator_pkg::*;

  localparam int DEPTH = 2 ** PHASE_W;

  logic [AMP_W-1:0] w_rom [DEPTH];
  logic [AMP_W-1:0] r_sv;

  // Half-LSB phase offset makes entry(v) == mirror entry(~v) exact, so the
  // table has no duplicated zero or peak sample.
  for (genvar g = 0; g < DEPTH; g++) begin : g_rom
    assign w_rom[g] = AMP_W'(sine_entry(g, PHASE_W));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sv <= '0;
    end else begin
      r_sv <= w_rom[v];
    end
  end

  assign sv = r_sv;

endmodule

// File: tb/tb_sine_lut.sv
// ---------------------------------------------------------------------------
// tb_sine_lut
//   Driver applies one (v, rst) pair per cycle on the falling edge and pushes
//   the expected sv for the following rising edge into exp_q. The monitor
//   samples sv shortly after every rising edge and pops/compares whenever
//   an expectation is pending. Expected magnitudes come from spot constants
//   or from a real-valued sin/cos model.
// ---------------------------------------------------------------------------
module tb_sine_lut;

  localparam int PHASE_W = 13;
  localparam int AMP_W   = 16;
  localparam int DEPTH   = 2 ** PHASE_W;

  // clock / reset
  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [PHASE_W-1:0] v   = '0;
  logic [AMP_W-1:0]   sv;

  always #5 clk = ~clk;

  sine_lut #(
    .PHASE_W(PHASE_W),
    .AMP_W  (AMP_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .v  (v),
    .sv (sv)
  );

  // scoreboard state
  logic [AMP_W-1:0] exp_q[$];
  bit               chk_q[$];
  bit               mono_q[$];
  string            tag_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  // reference model: plain real arithmetic on the defining formula
  function automatic int model_sin(input int idx);
    real a;
    a = (3.14159265358979323846 / 2.0) * (real'(idx) + 0.5) / real'(DEPTH);
    return $rtoi($floor(32767.0 * $sin(a) + 0.5));
  endfunction

  // Mirror image of idx is ~idx = DEPTH-1-idx, whose angle is pi/2 - a.
  function automatic int model_cos(input int idx);
    real a;
    a = (3.14159265358979323846 / 2.0) * (real'(idx) + 0.5) / real'(DEPTH);
    return $rtoi($floor(32767.0 * $cos(a) + 0.5));
  endfunction

  // driver tasks
  task automatic drive(input logic [PHASE_W-1:0] val, input logic rst_val,
                       input int exp_val, input bit chk, input bit mono,
                       input string tag);
    @(negedge clk);
    v   = val;
    rst = rst_val;
    exp_q.push_back(AMP_W'(exp_val));
    chk_q.push_back(chk);
    mono_q.push_back(mono);
    tag_q.push_back(tag);
  endtask

  task automatic lookup(input int idx, input int exp_val, input string tag);
    drive(PHASE_W'(idx), 1'b0, exp_val, 1'b1, 1'b0, tag);
  endtask

  // monitor
  logic [AMP_W-1:0] prev_sv   = '0;
  bit               have_prev = 1'b0;

  always @(posedge clk) begin
    logic [AMP_W-1:0] e;
    bit               c;
    bit               m;
    string            t;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      c = chk_q.pop_front();
      m = mono_q.pop_front();
      t = tag_q.pop_front();
      if (c) begin
        n_checks++;
        if (sv === e) n_pass++;
        else $display("FAIL %s: sv=%0d expected=%0d", t, sv, e);
      end
      if (m && have_prev) begin
        n_checks++;
        if (sv >= prev_sv) n_pass++;
        else $display("FAIL monotonic: sv=%0d after %0d", sv, prev_sv);
      end
      prev_sv   = sv;
      have_prev = m;
    end
  end

  // stimulus
  initial begin
    int r;
    int wait_cnt;

    // reset held three edges with a live index: output stays cleared
    for (int i = 0; i < 3; i++) drive(13'd4096, 1'b1, 0, 1'b1, 1'b0, "reset_hold");
    lookup(4096, 23172, "reset_release");

    // spot values with fixed one-edge latency
    lookup(0,    3,     "spot_v0");
    lookup(4095, 23168, "spot_v4095");
    lookup(4096, 23172, "spot_v4096");
    lookup(8191, 32767, "spot_v8191");

    // wrap-around handled as ordinary indices
    lookup(8190, 32767, "wrap_8190");
    lookup(8191, 32767, "wrap_8191");
    lookup(0,    3,     "wrap_0");
    lookup(1,    9,     "wrap_1");

    // full back-to-back sweep against the model, plus monotonic check
    for (int i = 0; i < DEPTH; i++)
      drive(PHASE_W'(i), 1'b0, model_sin(i), 1'b1, 1'b1, "sweep");

    // mirror pairs: table(v) ~ sin, table(~v) ~ cos
    for (int i = 0; i < 500; i++) begin
      r = int'($urandom_range(DEPTH - 1, 0));
      lookup(r, model_sin(r), "mirror_sin");
      lookup(int'(~PHASE_W'(r)), model_cos(r), "mirror_cos");
    end

    // unknown index: output ignored, next lookup must be unaffected
    drive('x, 1'b0, 0, 1'b0, 1'b0, "x_index");
    lookup(4096, 23172, "after_x");

    // reset mid-stream drops the in-flight lookup
    lookup(8191, 32767, "pre_midreset");
    drive(13'd8191, 1'b1, 0, 1'b1, 1'b0, "midreset");
    lookup(0, 3, "post_midreset");

    // random stream with occasional resets
    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(DEPTH - 1, 0));
      if ($urandom_range(15, 0) == 0)
        drive(PHASE_W'(r), 1'b1, 0, 1'b1, 1'b0, "rand_reset");
      else
        lookup(r, model_sin(r), "rand_lookup");
    end

    // drain with a bounded wait
    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    @(negedge clk);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: pending=%0d expected=0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
